// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-codes, flag bit positions and the sequencer state encoding.
// Used by both the ALU and alu_sequencer so the two always agree on encodings.
// Pure declarations, no logic.
package alu_pkg;

   // ALU operation codes
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_CAT = 4'b0011;

   // Bit positions inside alu_flags / flags_q
   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_SPARE = 3;

   // Sequencer state encoding
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_X = 3'd1,
      ST_LOAD_Y = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WR_LO  = 3'd4,
      ST_WR_HI  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one ALU command: load x and y from the databus, run the external ALU, write the result back.
// Latency: 2 data beats + ALU_LAT exec cycles + 1 (or 2 with ALU_SEQ_WIDE_RESULT_EN) granted write beats.
// Backpressure: one command in flight, cmd_ready low while busy; write beats stall indefinitely on bus_grant.
module alu_sequencer #(
   parameter int ALU_LAT = 1,
   parameter int OP_W    = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [OP_W-1:0] cmd_op,
   input  logic [7:0]      data_in,
   input  logic            data_in_valid,
   output logic [7:0]      alu_x,
   output logic [7:0]      alu_y,
   output logic [OP_W-1:0] alu_op,
   input  logic [15:0]     alu_out,
   input  logic [3:0]      alu_flags,
   output logic            bus_req,
   input  logic            bus_grant,
   output logic            bus_oe,
   output logic [7:0]      bus_data,
   output logic [3:0]      flags_q,
   output logic            busy
);
   import alu_pkg::*;

`ifdef ALU_SEQ_WIDE_RESULT_EN
   localparam int RES_W = 16;
`else
   localparam int RES_W = 8;
   // Upper result byte is never written back in the narrow build.
   logic unused_alu_hi;
   assign unused_alu_hi = ^alu_out[15:8];
`endif

   // Counter value on the final EXEC cycle.
   localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

   seq_state_e       state_q, state_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [7:0]       x_q, x_d;
   logic [7:0]       y_q, y_d;
   logic [RES_W-1:0] res_q, res_d;
   logic [3:0]       flg_q, flg_d;
   logic [2:0]       cnt_q, cnt_d;

   assign cmd_ready = (state_q == ST_IDLE) & ~reset;
   assign busy      = (state_q != ST_IDLE);
   assign bus_req   = (state_q == ST_WR_LO) | (state_q == ST_WR_HI);
   assign bus_oe    = bus_req & bus_grant;
   assign alu_x     = x_q;
   assign alu_y     = y_q;
   assign alu_op    = op_q;
   assign flags_q   = flg_q;

   // Select the result byte for the current write beat; zero when not writing.
   always_comb begin
      bus_data = 8'h00;
      case (state_q)
         ST_WR_LO: bus_data = res_q[7:0];
`ifdef ALU_SEQ_WIDE_RESULT_EN
         ST_WR_HI: bus_data = res_q[15:8];
`endif
         default:  bus_data = 8'h00;
      endcase
   end

   // Next-state logic; the counter idles at zero so every EXEC starts a fresh count.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      flg_d   = flg_q;
      cnt_d   = 3'd0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = cmd_op;
               state_d = ST_LOAD_X;
            end
         end
         ST_LOAD_X: begin
            if (data_in_valid) begin
               x_d     = data_in;
               state_d = ST_LOAD_Y;
            end
         end
         ST_LOAD_Y: begin
            if (data_in_valid) begin
               y_d     = data_in;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == LAT_LAST) begin
               res_d   = alu_out[RES_W-1:0];
               flg_d   = alu_flags;
               state_d = ST_WR_LO;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_WR_LO: begin
            if (bus_grant) begin
`ifdef ALU_SEQ_WIDE_RESULT_EN
               state_d = ST_WR_HI;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         ST_WR_HI: begin
            if (bus_grant) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         x_q     <= 8'h00;
         y_q     <= 8'h00;
         res_q   <= '0;
         flg_q   <= 4'h0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
